// File: rtl/shift_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// shift_pkg : funct/Shiftop encodings and the S1 entry type for shift_exec_stage
// Revision  : 1.0
// ---------------------------------------------------------------------------
package shift_pkg;

  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_SRL  = 6'b000010;
  localparam logic [5:0] FUNCT_SRA  = 6'b000011;
  localparam logic [5:0] FUNCT_SLLV = 6'b000100;
  localparam logic [5:0] FUNCT_SRLV = 6'b000110;
  localparam logic [5:0] FUNCT_SRAV = 6'b000111;

  localparam logic [1:0] SHOP_LL = 2'b00;
  localparam logic [1:0] SHOP_RL = 2'b10;
  localparam logic [1:0] SHOP_RA = 2'b11;

  typedef struct packed {
    logic [31:0] operand;
    logic [4:0]  amount;
    logic [1:0]  shiftop;
    logic [4:0]  rd;
    logic        illegal;
  } s1_entry;

  function automatic logic is_shift_funct(input logic [5:0] funct);
    return funct inside {FUNCT_SLL, FUNCT_SRL, FUNCT_SRA,
                         FUNCT_SLLV, FUNCT_SRLV, FUNCT_SRAV};
  endfunction

endpackage
`default_nettype wire

// File: rtl/shifter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// shifter : combinational 32-bit barrel shifter (LL / RL / RA)
// Revision: 1.0
// ---------------------------------------------------------------------------
module shifter
  import shift_pkg::*;
(
  input  logic [31:0] A,
  input  logic [4:0]  B,
  input  logic [1:0]  Shiftop,
  output logic [31:0] Result
);

  always_comb begin
    case (Shiftop)
      SHOP_LL: Result = A << B;
      SHOP_RL: Result = A >> B;
      SHOP_RA: Result = $unsigned($signed(A) >>> B);
      default: Result = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/shift_exec_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// shift_exec_stage : two-stage shift execute wrapper with valid/ready output.
// Optional build macro SHIFT_STATS_EN adds retire/stall/illegal counters.
// Revision: 1.0
// ---------------------------------------------------------------------------
module shift_exec_stage
  import shift_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [5:0]            in_funct,
  input  logic [4:0]            in_shamt,
  input  logic [DATA_WIDTH-1:0] in_rs,
  input  logic [DATA_WIDTH-1:0] in_rt,
  input  logic [REG_ADDR_W-1:0] in_rd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_wen,
  output logic                  out_illegal
`ifdef SHIFT_STATS_EN
  ,
  output logic [31:0]           stat_retired,
  output logic [31:0]           stat_stall,
  output logic [15:0]           stat_illegal
`endif
);

  s1_entry     s1_next;
  s1_entry     s1_q;
  logic        s1_valid;
  logic        s2_valid;
  logic        s2_free;
  logic        s1_adv;
  logic        in_fire;
  logic [31:0] sh_result;
  logic        unused_rs;

  assign unused_rs = ^in_rs[DATA_WIDTH-1:5];

  assign s2_free  = !s2_valid || out_ready;
  assign s1_adv   = s1_valid && s2_free;
  assign in_ready = !flush && (!s1_valid || s2_free);
  assign in_fire  = in_valid && in_ready;

  // Illegal ops carry SHOP_LL so the unused 01 encoding never reaches the shifter.
  always_comb begin
    s1_next.illegal = !is_shift_funct(in_funct);
    s1_next.operand = in_rt;
    s1_next.amount  = in_funct[2] ? in_rs[4:0] : in_shamt;
    s1_next.shiftop = s1_next.illegal ? SHOP_LL : in_funct[1:0];
    s1_next.rd      = in_rd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_q     <= s1_next;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  shifter u_shifter (
    .A       (s1_q.operand),
    .B       (s1_q.amount),
    .Shiftop (s1_q.shiftop),
    .Result  (sh_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid    <= 1'b0;
      out_result  <= '0;
      out_rd      <= '0;
      out_wen     <= 1'b0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      s2_valid <= 1'b0;
    end else if (s1_adv) begin
      s2_valid    <= 1'b1;
      out_result  <= s1_q.illegal ? '0 : sh_result;
      out_rd      <= s1_q.rd;
      out_wen     <= !s1_q.illegal && (s1_q.rd != '0);
      out_illegal <= s1_q.illegal;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  assign out_valid = s2_valid;

`ifdef SHIFT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_retired <= '0;
      stat_stall   <= '0;
      stat_illegal <= '0;
    end else begin
      if (out_valid && out_ready) begin
        if (out_illegal) stat_illegal <= stat_illegal + 16'd1;
        else             stat_retired <= stat_retired + 32'd1;
      end
      if (out_valid && !out_ready) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_shift_exec_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_shift_exec_stage : scoreboard bench with randomized shift traffic
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_shift_exec_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_funct = '0;
  logic [4:0]  in_shamt = '0;
  logic [31:0] in_rs = '0;
  logic [31:0] in_rt = '0;
  logic [4:0]  in_rd = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic        out_illegal;
`ifdef SHIFT_STATS_EN
  logic [31:0] stat_retired;
  logic [31:0] stat_stall;
  logic [15:0] stat_illegal;
`endif

  shift_exec_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_funct(in_funct), .in_shamt(in_shamt), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_wen(out_wen), .out_illegal(out_illegal)
`ifdef SHIFT_STATS_EN
    , .stat_retired(stat_retired), .stat_stall(stat_stall), .stat_illegal(stat_illegal)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        wen;
    logic        illegal;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          stall_cnt = 0;
  bit          rand_ready = 1'b0;
  int          accepts = 0;
  int          block_at = -1;
  bit          prev_stall = 1'b0;
  logic [38:0] prev_out;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: shift rules applied directly from the instruction semantics.
  function automatic exp_t model(input logic [5:0] f, input logic [4:0] sh,
                                 input logic [31:0] rs, input logic [31:0] rt,
                                 input logic [4:0] rd);
    exp_t        e;
    int          amt;
    logic [31:0] r;
    amt = (f == 6'd4 || f == 6'd6 || f == 6'd7) ? int'(rs[4:0]) : int'(sh);
    r = rt;
    e.illegal = 1'b0;
    case (f)
      6'd0, 6'd4: r = rt << amt;
      6'd2, 6'd6: r = rt >> amt;
      6'd3, 6'd7: for (int i = 0; i < amt; i++) r = {r[31], r[31:1]};
      default: begin r = 32'd0; e.illegal = 1'b1; end
    endcase
    e.result = r;
    e.rd     = rd;
    e.wen    = !e.illegal && (rd != 5'd0);
    return e;
  endfunction

  always @(negedge clk) begin
    if (stall_cnt > 0) begin
      out_ready = 1'b0;
      stall_cnt--;
    end else if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    else out_ready = 1'b1;
  end

  task automatic send(input logic [5:0] f, input logic [4:0] sh, input logic [31:0] rs,
                      input logic [31:0] rt, input logic [4:0] rd);
    int waited = 0;
    @(negedge clk);
    in_valid = 1'b1; in_funct = f; in_shamt = sh; in_rs = rs; in_rt = rt; in_rd = rd;
    #1;
    while (!in_ready) begin
      if (block_at < 0) block_at = accepts;
      if (waited++ > 200) begin
        check("in_ready_timeout", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk); #1;
    end
    sb.push_back(model(f, sh, rs, rt, rd));
    accepts++;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Monitor: pops expected results on every output handshake and checks hold-stability.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst_n) prev_stall = 1'b0;
    else begin
      if (prev_stall && out_valid)
        check("stall_hold", {25'd0, out_result, out_rd, out_wen, out_illegal}, {25'd0, prev_out});
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("unexpected_output", {59'd0, out_rd}, 64'hFFFF);
        else begin
          e = sb.pop_front();
          check("result",  {32'd0, out_result}, {32'd0, e.result});
          check("rd",      {59'd0, out_rd},     {59'd0, e.rd});
          check("wen",     {63'd0, out_wen},    {63'd0, e.wen});
          check("illegal", {63'd0, out_illegal}, {63'd0, e.illegal});
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_result, out_rd, out_wen, out_illegal};
    end
  end

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin @(posedge clk); n++; end
    check("drain_remaining", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] legal_f [6];
    logic [5:0] f;
    legal_f = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7};

    #1;
    check("reset_outputs", {24'd0, out_valid, out_result, out_rd, out_wen, out_illegal}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);

    send(6'd0, 5'd31, 32'h0, 32'h0000_0001, 5'd3);
    check("latency_n", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    check("latency_n1", {63'd0, out_valid}, 64'd1);
    check("sll_result", {32'd0, out_result}, 64'h8000_0000);
    drain();

    send(6'd3, 5'd4, 32'h0, 32'h8000_0000, 5'd7);
    send(6'd2, 5'd4, 32'h0, 32'h8000_0000, 5'd8);
    send(6'd6, 5'd17, 32'hFFFF_FFE4, 32'hF000_0000, 5'd9);
    send(6'd1, 5'd2, 32'h0, 32'h1234_5678, 5'd5);
    send(6'd0, 5'd1, 32'h0, 32'h1234_5678, 5'd0);
    drain();

    stall_cnt = 4;
    accepts = 0; block_at = -1;
    for (int i = 0; i < 4; i++) send(6'd4, 5'd0, 32'(i + 1), 32'h0000_0F0F + 32'(i), 5'(10 + i));
    check("bp_block_after", 64'(block_at), 64'd2);
    drain();

    stall_cnt = 20;
    send(6'd7, 5'd0, 32'd3, 32'h8765_4321, 5'd1);
    send(6'd0, 5'd5, 32'd0, 32'h0000_00FF, 5'd2);
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_in_ready", {63'd0, in_ready}, 64'd0);
    check("flush_pre_valid", {63'd0, out_valid}, 64'd1);
    @(posedge clk); #1;
    sb.delete();
    stall_cnt = 0;
    check("flush_out_valid", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    flush = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("flush_stays_empty", {63'd0, out_valid}, 64'd0);

    stall_cnt = 20;
    send(6'd0, 5'd4, 32'd0, 32'h0000_1111, 5'd4);
    send(6'd2, 5'd1, 32'd0, 32'hFFFF_0000, 5'd6);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midreset_outputs", {24'd0, out_valid, out_result, out_rd, out_wen, out_illegal}, 64'd0);
    sb.delete();
    stall_cnt = 0;
    @(negedge clk);
    #3 rst_n = 1'b1;
    #1;
    check("midreset_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (3) @(posedge clk); #1;
    check("midreset_no_output", {63'd0, out_valid}, 64'd0);

    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      f = ($urandom_range(0, 3) != 0) ? legal_f[$urandom_range(0, 5)] : 6'($urandom);
      send(f, 5'($urandom), $urandom, $urandom, 5'($urandom));
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    end
    rand_ready = 1'b0;
    drain();

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_exec_stage.md
Name: shift_exec_stage

Overview:
- Two-stage execute-stage wrapper that feeds the team's combinational `shifter` block and registers its output.
- Accepts decoded R-type shift instructions from decode (sll/srl/sra/sllv/srlv/srav).
- Selects the shift amount and maps funct to Shiftop.
- Delivers the result with destination-register tag to writeback over a valid/ready handshake, at full throughput under backpressure.

Parameters:
- DATA_WIDTH, 32, datapath width; only 32 is supported.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous pipeline flush; kills both stages.
- in_valid  input  1  decode presents an instruction.
- in_ready  output  1  stage accepts the instruction this cycle.
- in_funct  input  6  R-type funct field.
- in_shamt  input  5  instruction shamt field.
- in_rs  input  32  rs operand; bits [4:0] are the variable shift amount.
- in_rt  input  32  rt operand; this is the value that is shifted.
- in_rd  input  5  destination register.
- out_valid  output  1  result available.
- out_ready  input  1  writeback accepts.
- out_result  output  32  shifted value.
- out_rd  output  5  destination register.
- out_wen  output  1  register-write enable; 0 for illegal funct or rd==0.
- out_illegal  output  1  funct was not a shift opcode.

Behaviour:
- Decode, all other funct values are illegal:
  - 000000 sll
  - 000010 srl
  - 000011 sra
  - 000100 sllv
  - 000110 srlv
  - 000111 srav
- Shiftop equals in_funct[1:0], giving LL=00, RL=10, RA=11.
- Shift amount is in_rs[4:0] when funct[2]=1, otherwise in_shamt.
- Stage S1 registers the operand, amount, Shiftop, rd and illegal flag on an input handshake (in_valid & in_ready).
- The `shifter` is driven combinationally from the S1 registers.
- Stage S2 registers the `shifter` Result, rd, wen and illegal flag when S1 advances.
- Handshake equations:
  - s2_free = !s2_valid | out_ready.
  - s1_adv = s1_valid & s2_free.
  - in_ready = !flush & (!s1_valid | s2_free).
- No combinational path from in_valid to out_valid. There is a combinational path from out_ready to in_ready.
- Latency: a handshake accepted at edge N gives out_valid high after edge N+1, held until out_ready.
- Throughput is one instruction per cycle while out_ready=1.
- Holding under backpressure: while out_valid=1 and out_ready=0, out_result, out_rd, out_wen and out_illegal hold stable. S1 holds its contents and in_ready follows the equation above.
- Illegal funct:
  - The instruction still flows through with out_illegal=1, out_wen=0 and out_result=0.
  - Shiftop=01 is never presented to the `shifter`. S1 stores 00 for illegal ops.
- rd==0 gives out_wen=0 and the result is still computed.
- Flush:
  - Clears s1_valid and s2_valid at the next edge.
  - A handshake in the same cycle is impossible because in_ready=0.
  - A simultaneous out_ready does not matter; out_valid is 0 after the edge.
- Reset:
  - Asynchronous on rst_n low. s1_valid=0, s2_valid=0.
  - All outputs are 0: out_valid, out_result, out_rd, out_wen, out_illegal.
  - in_ready=1 once rst_n is high.
  - Reset mid-operation discards in-flight instructions with no output produced.
- Data registers are also reset to 0, so outputs are deterministic.

Optional Feature:
- Macro SHIFT_STATS_EN, adding these ports:
  - stat_retired  output  32  count of output handshakes with out_illegal=0.
  - stat_stall  output  32  count of cycles with out_valid & !out_ready.
  - stat_illegal  output  16  count of retired illegal ops.
- Counter rules:
  - All counters reset to 0 and wrap modulo 2^width.
  - Counters are not cleared by flush.
- Without the macro: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package shift_pkg holds:
  - Funct constants FUNCT_SLL, FUNCT_SRL, FUNCT_SRA, FUNCT_SLLV, FUNCT_SRLV, FUNCT_SRAV.
  - Shiftop constants SHOP_LL=00, SHOP_RL=10, SHOP_RA=11.
  - An s1_entry struct typedef of {operand, amount, shiftop, rd, illegal}.
- One sub-module instance: the existing `shifter` (A=S1 operand, B=S1 amount, Shiftop=S1 shiftop).
- Decode and stage registers stay in this module.

Test Plan:
- sll, rt=0x00000001, shamt=31, rd=3 -> two cycles later out_result=0x80000000, out_rd=3, out_wen=1.
- sra, rt=0x80000000, shamt=4 -> 0xF8000000. srl on the same operands -> 0x08000000.
- srlv, rs=0xFFFFFFE4 (amount 4), rt=0xF0000000 -> 0x0F000000; shamt field ignored.
- Backpressure:
  - Stimulus: 4 back-to-back sllv ops, out_ready=0 for cycles 2-5, then 1.
  - Required: in_ready drops after two accepts; results retire in order with no loss or duplication; outputs stable while stalled.
- funct=000001, rd=5 -> out_illegal=1, out_wen=0, out_result=0. funct=000000 with rd=0 -> out_wen=0.
- Reset and flush:
  - Pulse rst_n low with two ops in flight -> all outputs 0 immediately, no result emitted.
  - flush with S1 and S2 full -> out_valid=0 next cycle.
